regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the Draig i32 register file's single write port. It takes NUM_REQ independent write requesters (e.g. ALU and load unit), each with a valid/ready handshake. A round-robin arbiter grants one per cycle and registers the winning write into a one-entry output stage that drives the register file write handshake. Writes to register 0 are accepted and discarded.

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DEFAULT_NUM_REQ = 2;
  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned REG_DATA_W      = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO_ADDR = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin request arbiter with one-hot grant and grant index.
// Build with DRAIG_WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_c
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr;

`ifdef DRAIG_WB_ARB_FIXED_PRIO_EN
  // Search always starts at requester 0; no pointer state exists.
  assign rr_ptr = '0;
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, advance};
`else
  // Pointer moves one past the requester just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end
`endif

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((CNT_W'(rr_ptr) + CNT_W'(k)) % CNT_W'(NUM_REQ));
      if (!found && req[cand]) begin
        found         = 1'b1;
        grant_c[cand] = 1'b1;
        grant_idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter feeding the register file's single write port.
// Optional build macro: DRAIG_WB_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [ADDR_WIDTH-1:0]         wr_addr_out,
  output logic [DATA_WIDTH-1:0]         wr_data_out,
  output logic                          wr_valid_out,
  input  logic                          wr_ready_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [IDX_W-1:0]      idx_d;

  logic                  load_en_c;
  logic                  accept_c;
  logic [NUM_REQ-1:0]    arb_req_c;
  logic [NUM_REQ-1:0]    grant_c;
  logic [IDX_W-1:0]      grant_idx_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_data_c;

  assign wr_valid_out  = (state_q == ST_FULL);
  assign load_en_c     = !wr_valid_out || wr_ready_in;
  // Readies stay low during reset and while the stage cannot take a write.
  assign arb_req_c     = (load_en_c && !rst) ? req_valid_in : '0;
  assign req_ready_out = grant_c;
  assign accept_c      = |grant_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (arb_req_c),
    .advance     (accept_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // Select the winning requester's payload.
  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_c == IDX_W'(i)) begin
        sel_addr_c = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_c = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output stage next state; zero-address writes are consumed but never presented.
  always_comb begin
    state_d = state_q;
    addr_d  = wr_addr_out;
    data_d  = wr_data_out;
    idx_d   = grant_idx_out;
    if (accept_c) begin
      if (sel_addr_c != ADDR_WIDTH'(REG_ZERO_ADDR)) begin
        state_d = ST_FULL;
        addr_d  = sel_addr_c;
        data_d  = sel_data_c;
        idx_d   = grant_idx_c;
      end else begin
        state_d = ST_EMPTY;
      end
    end else if (wr_ready_in) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      wr_addr_out   <= '0;
      wr_data_out   <= '0;
      grant_idx_out <= '0;
    end else begin
      state_q       <= state_d;
      wr_addr_out   <= addr_d;
      wr_data_out   <= data_d;
      grant_idx_out <= idx_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with two requesters.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  req_addr_in;
  logic [63:0] req_data_in;
  logic [1:0]  req_valid_in;
  logic [1:0]  req_ready_out;
  logic [4:0]  wr_addr_out;
  logic [31:0] wr_data_out;
  logic        wr_valid_out;
  logic        wr_ready_in;
  logic [0:0]  grant_idx_out;

  int checks = 0;
  int fails  = 0;

  regfile_wb_arbiter #(
    .NUM_REQ    (2),
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_addr_in   (req_addr_in),
    .req_data_in   (req_data_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .wr_addr_out   (wr_addr_out),
    .wr_data_out   (wr_data_out),
    .wr_valid_out  (wr_valid_out),
    .wr_ready_in   (wr_ready_in),
    .grant_idx_out (grant_idx_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic idx, input logic v, input logic [4:0] a, input logic [31:0] d);
    if (idx == 1'b0) begin
      req_valid_in[0]   = v;
      req_addr_in[4:0]  = a;
      req_data_in[31:0] = d;
    end else begin
      req_valid_in[1]    = v;
      req_addr_in[9:5]   = a;
      req_data_in[63:32] = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    wr_ready_in = 1'b1;
    set_req(1'b0, 1'b1, 5'd3, 32'h0000_0003);
    set_req(1'b1, 1'b1, 5'd4, 32'h0000_0004);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (req_ready_out !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", req_ready_out); end
      checks++; if (wr_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", wr_valid_out); end
      checks++; if (wr_addr_out !== 5'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", wr_addr_out); end
      checks++; if (wr_data_out !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", wr_data_out); end
      checks++; if (grant_idx_out !== 1'b0) begin fails++; $display("FAIL reset_idx: got %0d want 0", grant_idx_out); end
    end
    set_req(1'b0, 1'b0, 5'd0, 32'd0);
    set_req(1'b1, 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    checks++; if (req_ready_out !== 2'b01) begin fails++; $display("FAIL single_ready: got %b want 01", req_ready_out); end
    step();
    set_req(1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (wr_valid_out !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", wr_valid_out); end
    checks++; if (wr_addr_out !== 5'd5) begin fails++; $display("FAIL single_addr: got %0d want 5", wr_addr_out); end
    checks++; if (wr_data_out !== 32'hDEAD_BEEF) begin fails++; $display("FAIL single_data: got %h want deadbeef", wr_data_out); end
    checks++; if (grant_idx_out !== 1'b0) begin fails++; $display("FAIL single_idx: got %0d want 0", grant_idx_out); end
    step();
    checks++; if (wr_valid_out !== 1'b0) begin fails++; $display("FAIL single_drain: got %b want 0", wr_valid_out); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy [4];
    logic [4:0] exp_addr [4];
    logic       exp_idx [4];
`ifdef DRAIG_WB_ARB_FIXED_PRIO_EN
    exp_rdy  = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_addr = '{5'd1, 5'd1, 5'd1, 5'd1};
    exp_idx  = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr = '{5'd1, 5'd2, 5'd1, 5'd2};
    exp_idx  = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    wr_ready_in = 1'b1;
    set_req(1'b0, 1'b1, 5'd1, 32'h0000_0100);
    set_req(1'b1, 1'b1, 5'd2, 32'h0000_0200);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req_ready_out !== exp_rdy[c]) begin fails++; $display("FAIL cont_ready[%0d]: got %b want %b", c, req_ready_out, exp_rdy[c]); end
      step();
      checks++; if (wr_valid_out !== 1'b1) begin fails++; $display("FAIL cont_valid[%0d]: got %b want 1", c, wr_valid_out); end
      checks++; if (wr_addr_out !== exp_addr[c]) begin fails++; $display("FAIL cont_addr[%0d]: got %0d want %0d", c, wr_addr_out, exp_addr[c]); end
      checks++; if (grant_idx_out !== exp_idx[c]) begin fails++; $display("FAIL cont_idx[%0d]: got %0d want %0d", c, grant_idx_out, exp_idx[c]); end
    end
    set_req(1'b0, 1'b0, 5'd0, 32'd0);
    set_req(1'b1, 1'b0, 5'd0, 32'd0);
    step();
    checks++; if (wr_valid_out !== 1'b0) begin fails++; $display("FAIL cont_drain: got %b want 0", wr_valid_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    wr_ready_in = 1'b1;
    set_req(1'b0, 1'b1, 5'd9, 32'h0000_0099);
    step();
    set_req(1'b0, 1'b0, 5'd0, 32'd0);
    set_req(1'b1, 1'b1, 5'd10, 32'h0000_00AA);
    wr_ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready_out !== 2'b00) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 00", c, req_ready_out); end
      step();
      checks++; if (wr_valid_out !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b want 1", c, wr_valid_out); end
      checks++; if (wr_addr_out !== 5'd9) begin fails++; $display("FAIL bp_addr[%0d]: got %0d want 9", c, wr_addr_out); end
      checks++; if (wr_data_out !== 32'h0000_0099) begin fails++; $display("FAIL bp_data[%0d]: got %h want 99", c, wr_data_out); end
    end
    wr_ready_in = 1'b1;
    #1;
    checks++; if (req_ready_out !== 2'b10) begin fails++; $display("FAIL bp_release_ready: got %b want 10", req_ready_out); end
    step();
    set_req(1'b1, 1'b0, 5'd0, 32'd0);
    checks++; if (wr_valid_out !== 1'b1) begin fails++; $display("FAIL bp_nobubble_valid: got %b want 1", wr_valid_out); end
    checks++; if (wr_addr_out !== 5'd10) begin fails++; $display("FAIL bp_next_addr: got %0d want 10", wr_addr_out); end
    checks++; if (wr_data_out !== 32'h0000_00AA) begin fails++; $display("FAIL bp_next_data: got %h want aa", wr_data_out); end
    checks++; if (grant_idx_out !== 1'b1) begin fails++; $display("FAIL bp_next_idx: got %0d want 1", grant_idx_out); end
    step();
    checks++; if (wr_valid_out !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", wr_valid_out); end
  endtask

  task automatic test_zero_drop();
    do_reset();
    wr_ready_in = 1'b1;
    set_req(1'b0, 1'b1, 5'd3, 32'h0000_0033);
    step();
    set_req(1'b0, 1'b0, 5'd0, 32'd0);
    set_req(1'b1, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    checks++; if (req_ready_out !== 2'b10) begin fails++; $display("FAIL zero_ready: got %b want 10", req_ready_out); end
    step();
    checks++; if (wr_valid_out !== 1'b0) begin fails++; $display("FAIL zero_valid: got %b want 0", wr_valid_out); end
    checks++; if (wr_addr_out !== 5'd3) begin fails++; $display("FAIL zero_addr_hold: got %0d want 3", wr_addr_out); end
    checks++; if (wr_data_out !== 32'h0000_0033) begin fails++; $display("FAIL zero_data_hold: got %h want 33", wr_data_out); end
    checks++; if (grant_idx_out !== 1'b0) begin fails++; $display("FAIL zero_idx_hold: got %0d want 0", grant_idx_out); end
    set_req(1'b0, 1'b1, 5'd4, 32'h0000_0044);
    set_req(1'b1, 1'b1, 5'd6, 32'h0000_0066);
    #1;
    checks++; if (req_ready_out !== 2'b01) begin fails++; $display("FAIL zero_next_ready: got %b want 01", req_ready_out); end
    step();
    set_req(1'b0, 1'b0, 5'd0, 32'd0);
    set_req(1'b1, 1'b0, 5'd0, 32'd0);
    checks++; if (wr_addr_out !== 5'd4) begin fails++; $display("FAIL zero_next_addr: got %0d want 4", wr_addr_out); end
    step();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    wr_ready_in = 1'b1;
    set_req(1'b0, 1'b1, 5'd7, 32'h0000_0077);
    step();
    set_req(1'b0, 1'b0, 5'd0, 32'd0);
    wr_ready_in = 1'b0;
    checks++; if (wr_valid_out !== 1'b1) begin fails++; $display("FAIL hold_full: got %b want 1", wr_valid_out); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (wr_valid_out !== 1'b0) begin fails++; $display("FAIL hold_rst_valid: got %b want 0", wr_valid_out); end
    checks++; if (wr_addr_out !== 5'd0) begin fails++; $display("FAIL hold_rst_addr: got %0d want 0", wr_addr_out); end
    wr_ready_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (wr_valid_out !== 1'b0) begin fails++; $display("FAIL hold_lost[%0d]: got %b want 0", c, wr_valid_out); end
    end
  endtask

  initial begin
    rst          = 1'b1;
    req_addr_in  = '0;
    req_data_in  = '0;
    req_valid_in = '0;
    wr_ready_in  = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_zero_drop();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
